// File: rtl/rholang_load_arbiter.sv
// rholang_load_arbiter
// Shares the Rholang core program-load/execute port between NUM_REQ program
// sources. One requester at a time is granted round-robin, its word burst is
// passed straight through to the core, an optional start pulse follows, and
// the core is held until execution_done before the next grant.
// Optional RUN-state watchdog: compile with RHO_ARB_TIMEOUT_EN defined.
module rholang_load_arbiter #(
   parameter int NUM_REQ   = 2,
   parameter int MAX_BURST = 1024,
   parameter int TIMEOUT   = 65536
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [32*NUM_REQ-1:0]  req_data,
   input  logic [NUM_REQ-1:0]     req_last,
   input  logic [NUM_REQ-1:0]     req_start,
   output logic [NUM_REQ-1:0]     req_ready,
   output logic [31:0]            program_data,
   output logic                   program_valid,
   input  logic                   program_ready,
   output logic                   start_execution,
   input  logic                   execution_done,
   output logic [2:0]             grant_id,
   output logic                   busy,
   output logic                   err_overflow,
   output logic                   err_timeout,
   input  logic                   err_clear
);

   localparam int CNT_W = $clog2(MAX_BURST) + 1;
`ifdef RHO_ARB_TIMEOUT_EN
   localparam int TO_W  = $clog2(TIMEOUT);
`endif

   if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_BURST < 1 || TIMEOUT < 2) begin : g_param_check
      $error("rholang_load_arbiter: parameter out of range");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_STREAM,
      S_START,
      S_RUN
   } state_e;

   state_e             state_q;
   logic [2:0]         grant_q;
   logic [2:0]         last_grant_q;
   logic [CNT_W-1:0]   count_q;
   logic               start_q;
   logic               busy_q;
   logic               err_ov_q;
   logic [1:0]         rst_sync_q;
   logic               rst_n;

   logic [2:0]         grant_d;
   logic               pick_found;
   logic               g_valid;
   logic               g_last;
   logic               g_start;
   logic [31:0]        g_data;
   logic               xfer;
   logic [CNT_W-1:0]   count_inc;
   logic               ov_hit;
   logic               to_hit;

   // Reset synchronizer: assertion reaches every flop at once, release is aligned to clk.
   // NOTE: the async reset is released through two flops so no state flop sees reset
   // removal close to a clock edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) rst_sync_q <= 2'b00;
      else          rst_sync_q <= {rst_sync_q[0], 1'b1};
   end

   assign rst_n = rst_sync_q[1];

   // Round-robin pick: first requesting index after the last grant, wrapping.
   // NOTE: every variable written here gets a default first so no latch is inferred.
   always_comb begin
      pick_found = 1'b0;
      grant_d    = grant_q;
      for (int k = 1; k <= NUM_REQ; k++) begin
         for (int j = 0; j < NUM_REQ; j++) begin
            if (!pick_found && req_valid[j] &&
                (((int'(last_grant_q) + k) % NUM_REQ) == j)) begin
               pick_found = 1'b1;
               grant_d    = 3'(j);
            end
         end
      end
   end

   // Select the granted requester's word and sideband bits.
   always_comb begin
      g_valid = 1'b0;
      g_last  = 1'b0;
      g_start = 1'b0;
      g_data  = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (grant_q == 3'(j)) begin
            g_valid = req_valid[j];
            g_last  = req_last[j];
            g_start = req_start[j];
            g_data  = req_data[32*j +: 32];
         end
      end
   end

   // Zero-latency pass-through to the core while streaming; ready only to the granted source.
   always_comb begin
      req_ready = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         req_ready[j] = (state_q == S_STREAM) && (grant_q == 3'(j)) && program_ready;
      end
   end

   assign program_valid = (state_q == S_STREAM) && g_valid;
   assign program_data  = (state_q == S_STREAM) ? g_data : 32'h0;
   assign xfer          = program_valid && program_ready;
   assign count_inc     = count_q + CNT_W'(1);
   assign ov_hit        = xfer && !g_last && (count_inc == CNT_W'(MAX_BURST));

`ifdef RHO_ARB_TIMEOUT_EN
   logic [TO_W-1:0] run_cnt_q;
   logic            err_to_q;

   assign to_hit = (state_q == S_RUN) && !execution_done &&
                   (run_cnt_q == TO_W'(TIMEOUT - 1));
`else
   assign to_hit = 1'b0;
`endif

   // Main control FSM with registered start pulse and busy flag.
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         grant_q      <= 3'd0;
         last_grant_q <= 3'(NUM_REQ - 1);
         count_q      <= '0;
         start_q      <= 1'b0;
         busy_q       <= 1'b0;
`ifdef RHO_ARB_TIMEOUT_EN
         run_cnt_q    <= '0;
`endif
      end else begin
         start_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (pick_found) begin
                  grant_q <= grant_d;
                  count_q <= '0;
                  busy_q  <= 1'b1;
                  state_q <= S_STREAM;
               end
            end
            S_STREAM: begin
               if (xfer) begin
                  if (g_last) begin
                     last_grant_q <= grant_q;
                     if (g_start) begin
                        start_q <= 1'b1;
                        state_q <= S_START;
                     end else begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                     end
                  end else if (ov_hit) begin
                     // Burst cut short; the rest of the words wait for a fresh grant.
                     last_grant_q <= grant_q;
                     busy_q       <= 1'b0;
                     state_q      <= S_IDLE;
                  end else begin
                     count_q <= count_inc;
                  end
               end
            end
            S_START: begin
`ifdef RHO_ARB_TIMEOUT_EN
               run_cnt_q <= '0;
`endif
               state_q <= S_RUN;
            end
            S_RUN: begin
               if (execution_done || to_hit) begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
`ifdef RHO_ARB_TIMEOUT_EN
               else begin
                  run_cnt_q <= run_cnt_q + TO_W'(1);
               end
`endif
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // Sticky error flags; a set in the same cycle as err_clear wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_ov_q <= 1'b0;
`ifdef RHO_ARB_TIMEOUT_EN
         err_to_q <= 1'b0;
`endif
      end else begin
         if (ov_hit)         err_ov_q <= 1'b1;
         else if (err_clear) err_ov_q <= 1'b0;
`ifdef RHO_ARB_TIMEOUT_EN
         if (to_hit)         err_to_q <= 1'b1;
         else if (err_clear) err_to_q <= 1'b0;
`endif
      end
   end

   assign grant_id        = grant_q;
   assign busy            = busy_q;
   assign start_execution = start_q;
   assign err_overflow    = err_ov_q;
`ifdef RHO_ARB_TIMEOUT_EN
   assign err_timeout     = err_to_q;
`else
   assign err_timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_rholang_load_arbiter.sv
// Testbench for rholang_load_arbiter: per-requester word queues drive the
// sources, a round-robin reference model turns them into the expected core
// event stream, and a negedge monitor scores every word and start pulse.
module tb_rholang_load_arbiter;

   localparam int NUM_REQ   = 3;
   localparam int MAX_BURST = 8;
   localparam int TIMEOUT   = 16;

   typedef struct packed {
      logic [31:0] data;
      logic        last;
      logic        start;
   } word_t;

   typedef struct {
      bit          is_start;
      int          gid;
      logic [31:0] data;
   } exp_t;

   logic                  clk;
   logic                  reset_n;
   logic [NUM_REQ-1:0]    req_valid;
   logic [32*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]    req_last;
   logic [NUM_REQ-1:0]    req_start;
   logic [NUM_REQ-1:0]    req_ready;
   logic [31:0]           program_data;
   logic                  program_valid;
   logic                  program_ready;
   logic                  start_execution;
   logic                  execution_done;
   logic [2:0]            grant_id;
   logic                  busy;
   logic                  err_overflow;
   logic                  err_timeout;
   logic                  err_clear;

   rholang_load_arbiter #(
      .NUM_REQ   (NUM_REQ),
      .MAX_BURST (MAX_BURST),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .req_valid       (req_valid),
      .req_data        (req_data),
      .req_last        (req_last),
      .req_start       (req_start),
      .req_ready       (req_ready),
      .program_data    (program_data),
      .program_valid   (program_valid),
      .program_ready   (program_ready),
      .start_execution (start_execution),
      .execution_done  (execution_done),
      .grant_id        (grant_id),
      .busy            (busy),
      .err_overflow    (err_overflow),
      .err_timeout     (err_timeout),
      .err_clear       (err_clear)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int    checks = 0;
   int    errors = 0;
   word_t d_q [NUM_REQ][$];   // words still to be offered by each source
   word_t m_q [NUM_REQ][$];   // same words, consumed by the reference model
   exp_t  exp_q [$];          // expected core-side events in order
   int    m_last = NUM_REQ - 1;
   bit    exp_ovf = 1'b0;
   bit    done_auto = 1'b1;
   bit    ready_always = 1'b0;
   int    done_cnt = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic void add_word(input int r, input logic [31:0] data,
                                    input logic last, input logic start);
      word_t w;
      w.data  = data;
      w.last  = last;
      w.start = start;
      d_q[r].push_back(w);
      m_q[r].push_back(w);
   endfunction

   function automatic void add_burst(input int r, input int len, input logic start);
      for (int i = 0; i < len; i++)
         add_word(r, $urandom, (i == len - 1), start && (i == len - 1));
   endfunction

   // Reference: all sources with pending words compete; winner is the first
   // pending index after the previous winner. A grant carries words until one
   // marked last or until MAX_BURST words have gone without one.
   function automatic void run_model();
      int    g;
      int    n;
      word_t w;
      exp_t  e;
      forever begin
         g = -1;
         for (int k = 1; k <= NUM_REQ; k++) begin
            int r = (m_last + k) % NUM_REQ;
            if (g < 0 && m_q[r].size() > 0) g = r;
         end
         if (g < 0) break;
         n = 0;
         w = '0;
         while (m_q[g].size() > 0 && n < MAX_BURST) begin
            w = m_q[g].pop_front();
            e.is_start = 1'b0;
            e.gid      = g;
            e.data     = w.data;
            exp_q.push_back(e);
            n++;
            if (w.last) break;
         end
         if (w.last) begin
            if (w.start) begin
               e.is_start = 1'b1;
               e.gid      = g;
               e.data     = '0;
               exp_q.push_back(e);
            end
         end else if (n == MAX_BURST) begin
            exp_ovf = 1'b1;
         end
         m_last = g;
      end
   endfunction

   // Scoreboard monitor.
   exp_t               mon_e;
   logic [NUM_REQ-1:0] exp_rdy;
   always @(negedge clk) begin
      if (reset_n) begin
         if (program_valid && program_ready) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_word: got 0x%0h expected no word", program_data);
            end else begin
               mon_e = exp_q.pop_front();
               if (mon_e.is_start) begin
                  checks++; errors++;
                  $display("FAIL event_order: got word 0x%0h expected start pulse", program_data);
               end else begin
                  exp_rdy = '0;
                  exp_rdy[mon_e.gid] = 1'b1;
                  check("word_data", program_data, mon_e.data);
                  check("word_grant", grant_id, mon_e.gid);
                  check("req_ready_onehot", req_ready, exp_rdy);
               end
            end
         end
         if (start_execution) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_start: got start pulse expected none (grant %0d)", grant_id);
            end else begin
               mon_e = exp_q.pop_front();
               if (!mon_e.is_start) begin
                  checks++; errors++;
                  $display("FAIL event_order: got start pulse expected word 0x%0h", mon_e.data);
               end else begin
                  check("start_grant", grant_id, mon_e.gid);
               end
            end
         end
      end
   end

   function automatic bit all_empty();
      for (int r = 0; r < NUM_REQ; r++)
         if (d_q[r].size() > 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic drive();
      for (int r = 0; r < NUM_REQ; r++) begin
         if (d_q[r].size() > 0) begin
            req_valid[r]          = 1'b1;
            req_data[32*r +: 32]  = d_q[r][0].data;
            req_last[r]           = d_q[r][0].last;
            req_start[r]          = d_q[r][0].start;
         end else begin
            req_valid[r]          = 1'b0;
            req_data[32*r +: 32]  = 32'h0;
            req_last[r]           = 1'b0;
            req_start[r]          = 1'b0;
         end
      end
      program_ready = ready_always ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (done_cnt > 0) begin
         done_cnt--;
         execution_done = (done_cnt == 0);
      end else begin
         // Stray done pulses land outside RUN and must be ignored.
         execution_done = done_auto && ($urandom_range(0, 7) == 0);
      end
   endtask

   // Inputs change #1 after posedge; handshakes are observed at negedge.
   task automatic run_phase(input string name, input int max_cycles,
                            input int abort_words, input bit stop_on_start);
      int cyc   = 0;
      int nxfer = 0;
      bit fin   = 1'b0;
      done_cnt = 0;
      @(posedge clk); #1;
      drive();
      while (!fin) begin
         @(negedge clk);
         for (int r = 0; r < NUM_REQ; r++) begin
            if (req_valid[r] && req_ready[r]) begin
               void'(d_q[r].pop_front());
               nxfer++;
            end
         end
         if (start_execution) begin
            if (stop_on_start) fin = 1'b1;
            else if (done_auto) done_cnt = $urandom_range(1, 4);
         end
         if (abort_words > 0 && nxfer >= abort_words) fin = 1'b1;
         if (!fin) begin
            @(posedge clk); #1;
            cyc++;
            drive();
            if (all_empty() && exp_q.size() == 0 && !busy && done_cnt == 0) begin
               fin = 1'b1;
               execution_done = 1'b0;
            end else if (cyc > max_cycles) begin
               checks++; errors++;
               $display("FAIL %s_cycle_budget: got %0d pending events expected 0 after %0d cycles",
                        name, exp_q.size(), cyc);
               fin = 1'b1;
            end
         end
      end
   endtask

   task automatic clear_errors();
      @(posedge clk); #1 err_clear = 1'b1;
      @(posedge clk); #1 err_clear = 1'b0;
      @(negedge clk);
      check("err_overflow_cleared", err_overflow, 0);
      check("err_timeout_cleared", err_timeout, 0);
      exp_ovf = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_time_limit: got no end of test expected $finish");
      $fatal(1, "time limit");
   end

   int n;

   initial begin
      reset_n        = 1'b1;
      req_valid      = '0;
      req_data       = '0;
      req_last       = '0;
      req_start      = '0;
      program_ready  = 1'b0;
      execution_done = 1'b0;
      err_clear      = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      check("rst_program_valid", program_valid, 0);
      check("rst_req_ready", req_ready, 0);
      check("rst_start", start_execution, 0);
      check("rst_busy", busy, 0);
      check("rst_grant_id", grant_id, 0);
      check("rst_err_overflow", err_overflow, 0);
      check("rst_err_timeout", err_timeout, 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      // Requesters 0 and 1 both valid from reset: alternation 0,1,0,1...
      for (int b = 0; b < 3; b++) begin
         add_burst(0, 2, 1'b0);
         add_burst(1, 2, 1'b0);
      end
      run_model();
      run_phase("alternate", 500, 0, 0);

      // Directed 4-word burst with start, core always ready.
      ready_always = 1'b1;
      add_word(0, 32'hA0, 1'b0, 1'b0);
      add_word(0, 32'hA1, 1'b0, 1'b0);
      add_word(0, 32'hA2, 1'b0, 1'b0);
      add_word(0, 32'hA3, 1'b1, 1'b1);
      run_model();
      run_phase("burst_a0", 200, 0, 0);
      check("burst_a0_idle", busy, 0);
      ready_always = 1'b0;

      // Randomised traffic; bursts longer than MAX_BURST overflow and resume.
      for (int b = 0; b < 30; b++)
         add_burst($urandom_range(0, NUM_REQ - 1), $urandom_range(1, 12), 1'($urandom_range(0, 1)));
      run_model();
      run_phase("random", 5000, 0, 0);
      check("random_err_overflow", err_overflow, exp_ovf);
      clear_errors();

      // Directed overflow: 12 words with last only on the 12th, plus a competitor.
      for (int i = 0; i < 12; i++) add_word(0, 32'hB000 + i, (i == 11), (i == 11));
      add_burst(1, 2, 1'b0);
      run_model();
      run_phase("overflow", 500, 0, 0);
      check("overflow_flag", err_overflow, 1);
      clear_errors();

      // RUN with no execution_done.
      ready_always = 1'b1;
      done_auto    = 1'b0;
      add_word(0, 32'hC0DE, 1'b1, 1'b1);
      run_model();
      run_phase("to_start", 100, 0, 1);
      n = 0;
`ifdef RHO_ARB_TIMEOUT_EN
      while (busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("timeout_cycles", n, TIMEOUT + 1);
      check("timeout_flag", err_timeout, 1);
      check("timeout_idle", busy, 0);
      clear_errors();
`else
      repeat (40) @(negedge clk);
      check("no_timeout_busy", busy, 1);
      check("no_timeout_flag", err_timeout, 0);
      @(posedge clk); #1 execution_done = 1'b1;
      @(posedge clk); #1 execution_done = 1'b0;
      @(negedge clk);
      check("done_releases_run", busy, 0);
`endif
      check("to_events_drained", exp_q.size(), 0);
      ready_always = 1'b0;
      done_auto    = 1'b1;

      // Reset mid-burst: requester 1 is next in line, abort after 2 of its words.
      add_burst(0, 4, 1'b0);
      add_burst(1, 6, 1'b0);
      run_model();
      ready_always = 1'b1;
      run_phase("pre_reset", 200, 2, 0);
      check("pre_reset_grant", grant_id, 1);
      #1 reset_n = 1'b0;
      #1;
      check("mid_rst_program_valid", program_valid, 0);
      check("mid_rst_req_ready", req_ready, 0);
      check("mid_rst_start", start_execution, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_grant_id", grant_id, 0);
      for (int r = 0; r < NUM_REQ; r++) begin
         d_q[r].delete();
         m_q[r].delete();
      end
      exp_q.delete();
      m_last  = NUM_REQ - 1;
      exp_ovf = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      ready_always = 1'b0;
      add_burst(1, 2, 1'b1);
      add_burst(0, 2, 1'b0);
      run_model();
      run_phase("post_reset", 500, 0, 0);
      check("post_reset_err_overflow", err_overflow, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
